// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus: display read path, pixel writer, clear control
// and the single-port RAM interface, bundled so the arbiter sees one port.
interface fb_arbiter_if #(
   parameter int ADDR_W = 16
);
   // display read path
   logic              disp_req;
   logic [7:0]        disp_x;
   logic [7:0]        disp_y;
   logic [7:0]        disp_data;
   logic              disp_valid;
   // game-logic pixel writer
   logic              wr_valid;
   logic              wr_ready;
   logic [7:0]        wr_x;
   logic [7:0]        wr_y;
   logic [7:0]        wr_data;
   // frame-clear control and status
   logic              clear_start;
   logic [7:0]        clear_color;
   logic              clear_busy;
   logic              clear_done;
   logic              oob_drop;
   // synchronous RAM port
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   // arbiter side
   modport slave (
      input  disp_req, disp_x, disp_y,
      output disp_data, disp_valid,
      input  wr_valid, wr_x, wr_y, wr_data,
      output wr_ready,
      input  clear_start, clear_color,
      output clear_busy, clear_done, oob_drop,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata
   );

   // requester / RAM side
   modport master (
      output disp_req, disp_x, disp_y,
      input  disp_data, disp_valid,
      output wr_valid, wr_x, wr_y, wr_data,
      input  wr_ready,
      output clear_start, clear_color,
      input  clear_busy, clear_done, oob_drop,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter. One RAM is shared between the display
// read path (highest priority, never stalled), the frame-clear engine and
// the pixel writer (lowest). Display reads return three clocks after the
// request: address register, RAM output register, disp_data register.
module fb_arbiter #(
   parameter int WIDTH  = 256,
   parameter int HEIGHT = 240,
   parameter int ADDR_W = 16
) (
   input  logic         clk_in,
   input  logic         rst_n,
   fb_arbiter_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam logic [7:0] CX_LAST = 8'(WIDTH - 1);
   localparam logic [7:0] CY_LAST = 8'(HEIGHT - 1);

   // Linear pixel address, truncated to the RAM address width.
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x,
                                                  input logic [7:0] y);
      logic [31:0] full;
      full = (32'(y) * 32'(WIDTH)) + 32'(x);
      return full[ADDR_W-1:0];
   endfunction

   // Coordinates compared at 32 bits so that WIDTH/HEIGHT of 256 are legal.
   function automatic logic pix_in_range(input logic [7:0] x,
                                         input logic [7:0] y);
      return (32'(x) < 32'(WIDTH)) && (32'(y) < 32'(HEIGHT));
   endfunction

   state_t            state_q,      state_d;
   logic [7:0]        cx_q,         cx_d;
   logic [7:0]        cy_q,         cy_d;
   logic [7:0]        color_q,      color_d;
   logic              busy_q,       busy_d;
   logic              done_q,       done_d;
   logic              oob_q,        oob_d;
   logic [ADDR_W-1:0] addr_q,       addr_d;
   logic              we_q,         we_d;
   logic [7:0]        wdata_q,      wdata_d;
   logic              rd_p1_q,      rd_p1_d;
   logic              rd_p2_q,      rd_p2_d;
   logic              dvalid_q,     dvalid_d;
   logic [7:0]        ddata_q,      ddata_d;

   logic              wr_ready_s;
   logic              wr_xfer_s;
   logic              clear_last_s;

   // Writer handshake: only when idle, not in reset and display is quiet.
   always_comb begin
      wr_ready_s   = rst_n && !bus.disp_req && (state_q == ST_IDLE);
      wr_xfer_s    = bus.wr_valid && wr_ready_s;
      clear_last_s = (cx_q == CX_LAST) && (cy_q == CY_LAST);
   end

   // Per-cycle grant, clear sequencing and read-pipeline next state.
   always_comb begin
      state_d  = state_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      color_d  = color_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      oob_d    = 1'b0;
      addr_d   = addr_q;
      we_d     = 1'b0;
      wdata_d  = wdata_q;

      if (bus.disp_req) begin
         addr_d = pix_addr(bus.disp_x, bus.disp_y);
      end else if (state_q == ST_CLEAR) begin
         we_d    = 1'b1;
         addr_d  = pix_addr(cx_q, cy_q);
         wdata_d = color_q;
         if (clear_last_s) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cx_d    = 8'd0;
            cy_d    = 8'd0;
         end else if (cx_q == CX_LAST) begin
            cx_d = 8'd0;
            cy_d = cy_q + 8'd1;
         end else begin
            cx_d = cx_q + 8'd1;
         end
      end else if (wr_xfer_s) begin
         if (pix_in_range(bus.wr_x, bus.wr_y)) begin
            we_d    = 1'b1;
            addr_d  = pix_addr(bus.wr_x, bus.wr_y);
            wdata_d = bus.wr_data;
         end else begin
            oob_d = 1'b1;
         end
      end else begin
         we_d = 1'b0;
      end

      // A start pulse only matters when idle; during a clear it is ignored.
      case (state_q)
         ST_IDLE: begin
            if (bus.clear_start) begin
               state_d = ST_CLEAR;
               busy_d  = 1'b1;
               color_d = bus.clear_color;
               cx_d    = 8'd0;
               cy_d    = 8'd0;
            end else begin
               state_d = state_q;
            end
         end
         ST_CLEAR: begin
            color_d = color_q;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Read pipeline: one valid token per display request, three deep.
      rd_p1_d  = bus.disp_req;
      rd_p2_d  = rd_p1_q;
      dvalid_d = rd_p2_q;
      if (rd_p2_q) begin
         ddata_d = bus.mem_rdata;
      end else begin
         ddata_d = ddata_q;
      end
   end

   // All state and all registered outputs; synchronous active-low reset.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cx_q     <= 8'd0;
         cy_q     <= 8'd0;
         color_q  <= 8'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         oob_q    <= 1'b0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= 8'd0;
         rd_p1_q  <= 1'b0;
         rd_p2_q  <= 1'b0;
         dvalid_q <= 1'b0;
         ddata_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         color_q  <= color_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         oob_q    <= oob_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         rd_p1_q  <= rd_p1_d;
         rd_p2_q  <= rd_p2_d;
         dvalid_q <= dvalid_d;
         ddata_q  <= ddata_d;
      end
   end

   assign bus.wr_ready   = wr_ready_s;
   assign bus.disp_data  = ddata_q;
   assign bus.disp_valid = dvalid_q;
   assign bus.clear_busy = busy_q;
   assign bus.clear_done = done_q;
   assign bus.oob_drop   = oob_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_we     = we_q;
   assign bus.mem_wdata  = wdata_q;

endmodule
